// File: rtl/edge_seq_monitor.sv
// Four-stage edge/event sequence monitor: waits on per-stage edge or event
// conditions and emits a timestamped hit strobe for each satisfied stage.
module edge_seq_monitor #(
  parameter int TS_W = 32,
  parameter bit LOOP = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic            sig1,
  input  logic            sig2,
  input  logic            ev,
  output logic            hit,
  output logic [1:0]      hit_stage,
  output logic [TS_W-1:0] hit_ts,
  output logic [1:0]      stage,
  output logic            done
);

  // state | meaning
  // S0    | wait posedge sig1 or ev
  // S1    | wait posedge sig2 or ev
  // S2    | wait posedge sig1 or negedge sig2
  // S3    | wait negedge sig1 or posedge sig2
  // DONE  | sequence complete, inputs ignored until clr (LOOP=0 only)
  typedef enum logic [2:0] {S0, S1, S2, S3, DONE} state_t;

  state_t          state, state_nx;
  logic [TS_W-1:0] ts;
  logic            sig1_q, sig2_q;
  logic            pos1, neg1, pos2, neg2;
  logic            cond;
  logic            hit_nx;
  logic [1:0]      hit_stage_nx;
  logic [TS_W-1:0] hit_ts_nx;
  logic            done_nx;
  logic [1:0]      stage_cur;

  assign pos1 = sig1 & ~sig1_q;
  assign neg1 = ~sig1 & sig1_q;
  assign pos2 = sig2 & ~sig2_q;
  assign neg2 = ~sig2 & sig2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S0;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    hit_nx       = 1'b0;
    hit_stage_nx = hit_stage;
    hit_ts_nx    = hit_ts;
    done_nx      = LOOP ? 1'b0 : (state == DONE);
    cond         = 1'b0;
    stage_cur    = 2'd0;

    case (state)
      S0:      begin cond = pos1 | ev;   stage_cur = 2'd0; end
      S1:      begin cond = pos2 | ev;   stage_cur = 2'd1; end
      S2:      begin cond = pos1 | neg2; stage_cur = 2'd2; end
      S3:      begin cond = neg1 | pos2; stage_cur = 2'd3; end
      default: begin cond = 1'b0;        stage_cur = 2'd3; end
    endcase

    // clr wins over any condition sampled in the same cycle
    if (clr) begin
      state_nx = S0;
      done_nx  = 1'b0;
    end else if (en && cond) begin
      hit_nx       = 1'b1;
      hit_stage_nx = stage_cur;
      hit_ts_nx    = ts;
      case (state)
        S0:      state_nx = S1;
        S1:      state_nx = S2;
        S2:      state_nx = S3;
        S3: begin
          state_nx = LOOP ? S0 : DONE;
          done_nx  = 1'b1;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts        <= '0;
      sig1_q    <= 1'b0;
      sig2_q    <= 1'b1;
      hit       <= 1'b0;
      hit_stage <= 2'd0;
      hit_ts    <= '0;
      done      <= 1'b0;
    end else begin
      ts        <= ts + {{(TS_W-1){1'b0}}, 1'b1};
      sig1_q    <= sig1;
      sig2_q    <= sig2;
      hit       <= hit_nx;
      hit_stage <= hit_stage_nx;
      hit_ts    <= hit_ts_nx;
      done      <= done_nx;
    end
  end

  assign stage = stage_cur;

endmodule
